// File: rtl/rv_csr_pkg.sv
// rtl/rv_csr_pkg.sv - CSR address constants, selector type and width helper for the counter bank
package rv_csr_pkg;

   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;

   // Widest selector needed for 255 events; narrower configs keep upper bits at zero.
   localparam int HPM_SEL_MAX_W = 8;
   typedef logic [HPM_SEL_MAX_W-1:0] t_hpm_sel;

   // Bits needed to encode selectors 0..num_events.
   function automatic int hpm_sel_width(input int num_events);
      return $clog2(num_events + 1);
   endfunction

endpackage

// File: rtl/rv_csr_counter.sv
// rtl/rv_csr_counter.sv - one wrapping counter with split 32-bit software write access
module rv_csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 inc,
   input  logic                 inhibit,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wr_data,
   output logic [CNT_WIDTH-1:0] value
);

   // Software writes beat the increment; the full-width add keeps the low-to-high carry atomic.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         value <= '0;
      end else if (wr_lo) begin
         value[31:0] <= wr_data;
      end else if (wr_hi) begin
         value[CNT_WIDTH-1:32] <= wr_data[CNT_WIDTH-33:0];
      end else if (inc && !inhibit) begin
         value <= value + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/rv_csr_hpm_counters.sv
// rtl/rv_csr_hpm_counters.sv - mcycle/minstret/mhpmcounter bank with event selectors and mcountinhibit
module rv_csr_hpm_counters
   import rv_csr_pkg::*;
#(
   parameter int NUM_HPM    = 4,
   parameter int NUM_EVENTS = 8,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_instruction_executed,
   input  logic [NUM_EVENTS-1:0] i_events,
   input  logic [11:0]           i_csr_addr,
   input  logic                  i_rd_en,
   input  logic                  i_wr_en,
   input  logic [31:0]           i_wr_data,
   output logic [31:0]           o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_illegal
);

   localparam int SEL_W       = hpm_sel_width(NUM_EVENTS);
   localparam int EV_W        = 2 ** SEL_W;
   localparam int NUM_CNT     = 2 + NUM_HPM;
   localparam int CYCLE_IDX   = int'(CSR_MCYCLE[4:0]);
   localparam int INSTRET_IDX = int'(CSR_MINSTRET[4:0]);
   localparam int HPM_LO      = int'(CSR_MHPMCOUNTER3[4:0]);
   localparam int HPM_HI      = HPM_LO + NUM_HPM;

   // Counter index (low 5 address bits) of the g-th physical counter.
   function automatic int slot_idx(input int g);
      if (g == 0) return CYCLE_IDX;
      if (g == 1) return INSTRET_IDX;
      return HPM_LO + g - 2;
   endfunction

   // Writable mcountinhibit bits: cycle, instret and the implemented hpm counters.
   function automatic logic [31:0] inh_mask_calc();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         m[i] = (i == CYCLE_IDX) || (i == INSTRET_IDX) || (i >= HPM_LO && i < HPM_HI);
      end
      return m;
   endfunction

   localparam logic [31:0] INH_MASK = inh_mask_calc();

   logic [4:0]           idx;
   logic                 hi;
   logic                 cnt_m;
   logic                 cnt_u;
   logic                 inh_hit;
   logic                 evt_hit;
   logic                 owned;
   logic                 wr_ok;
   logic [31:0]          inh_q;
   t_hpm_sel             evt_q [32];
   logic [EV_W-1:0]      ev_ext;
   logic [NUM_CNT-1:0]   cnt_inc;
   logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
   logic [63:0]          cnt_full [32];
   logic [31:0]          rd_mux;

   // Address decode; index 1 (time) is owned by another unit, user shadows are read-only.
   always_comb begin
      idx     = i_csr_addr[4:0];
      hi      = |(i_csr_addr & CSR_HI_OFFSET);
      cnt_m   = (i_csr_addr[11:8] == CSR_MCYCLE[11:8]) && (i_csr_addr[6:5] == 2'b00) && (idx != 5'd1);
      cnt_u   = (i_csr_addr[11:8] == CSR_CYCLE[11:8]) && (i_csr_addr[6:5] == 2'b00) && (idx != 5'd1);
      inh_hit = (i_csr_addr == CSR_MCOUNTINHIBIT);
      evt_hit = (i_csr_addr[11:5] == CSR_MCOUNTINHIBIT[11:5]) && (idx >= CSR_MHPMEVENT3[4:0]);
      owned   = cnt_m || cnt_u || inh_hit || evt_hit;
      wr_ok   = i_wr_en && owned && !cnt_u;
   end

   // mcountinhibit and WARL event selectors; unimplemented selector slots stay zero.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         inh_q <= '0;
         for (int i = 0; i < 32; i++) begin
            evt_q[5'(i)] <= '0;
         end
      end else if (wr_ok) begin
         if (inh_hit) begin
            inh_q <= i_wr_data & INH_MASK;
         end
         for (int i = HPM_LO; i < HPM_HI; i++) begin
            if (evt_hit && (idx == 5'(i))) begin
               evt_q[5'(i)] <= t_hpm_sel'(i_wr_data[SEL_W-1:0]);
            end
         end
      end
   end

   // Bit k is event k; bit 0 and selectors beyond NUM_EVENTS land on constant zero.
   assign ev_ext = EV_W'({i_events, 1'b0});

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      localparam int CI = slot_idx(g);

      if (g == 0) begin : g_cycle
         assign cnt_inc[g] = 1'b1;
      end else if (g == 1) begin : g_instret
         assign cnt_inc[g] = i_instruction_executed;
      end else begin : g_hpm
         assign cnt_inc[g] = ev_ext[evt_q[CI][SEL_W-1:0]];
      end

      rv_csr_counter #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_counter (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .inc       (cnt_inc[g]),
         .inhibit   (inh_q[CI]),
         .wr_lo     (wr_ok && cnt_m && (idx == 5'(CI)) && !hi),
         .wr_hi     (wr_ok && cnt_m && (idx == 5'(CI)) && hi),
         .wr_data   (i_wr_data),
         .value     (cnt_val[g])
      );
   end

   // Spread physical counters over the 32 index slots, zero-extended to 64 bits.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         cnt_full[i] = '0;
      end
      for (int g = 0; g < NUM_CNT; g++) begin
         cnt_full[5'(slot_idx(g))] = 64'(cnt_val[g]);
      end
   end

   // Read mux on the pre-increment state, so a same-cycle write returns the old value.
   always_comb begin
      rd_mux = '0;
      if (cnt_m || cnt_u) begin
         rd_mux = hi ? cnt_full[idx][63:32] : cnt_full[idx][31:0];
      end else if (inh_hit) begin
         rd_mux = inh_q;
      end else if (evt_hit) begin
         rd_mux = 32'(evt_q[idx]);
      end
   end

   // Registered response; read data holds between reads.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
         o_illegal  <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_en;
         o_illegal  <= (i_rd_en && !owned) || (i_wr_en && (!owned || cnt_u));
         if (i_rd_en) begin
            o_rd_data <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_rv_csr_hpm_counters.sv
// tb/tb_rv_csr_hpm_counters.sv - directed table and sequence checks for rv_csr_hpm_counters
module tb_rv_csr_hpm_counters;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        retire;
   logic [7:0]  events;
   logic [11:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic        wr_en40;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        illegal;
   logic [31:0] rd_data40;
   logic        rd_valid40;
   logic        illegal40;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_cnt;

   always #5 clk = ~clk;

   rv_csr_hpm_counters #(.NUM_HPM(4), .NUM_EVENTS(8), .CNT_WIDTH(64)) dut (
      .i_clk                  (clk),
      .i_reset_n              (rst_n),
      .i_instruction_executed (retire),
      .i_events               (events),
      .i_csr_addr             (addr),
      .i_rd_en                (rd_en),
      .i_wr_en                (wr_en),
      .i_wr_data              (wr_data),
      .o_rd_data              (rd_data),
      .o_rd_valid             (rd_valid),
      .o_illegal              (illegal)
   );

   rv_csr_hpm_counters #(.NUM_HPM(4), .NUM_EVENTS(8), .CNT_WIDTH(40)) dut40 (
      .i_clk                  (clk),
      .i_reset_n              (rst_n),
      .i_instruction_executed (retire),
      .i_events               (events),
      .i_csr_addr             (addr),
      .i_rd_en                (rd_en),
      .i_wr_en                (wr_en40),
      .i_wr_data              (wr_data),
      .o_rd_data              (rd_data40),
      .o_rd_valid             (rd_valid40),
      .o_illegal              (illegal40)
   );

   // Free-running model of mcycle while nothing writes or inhibits it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   typedef struct {
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] data;
      bit          chk_data;
      logic [31:0] exp_data;
      logic        exp_ill;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_rd(input logic [11:0] a);
      addr  = a;
      rd_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic do_wr(input logic [11:0] a, input logic [31:0] d, input logic w_main, input logic w_40);
      addr    = a;
      wr_data = d;
      wr_en   = w_main;
      wr_en40 = w_40;
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
      wr_en40 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_c;
      int c_w;

      tbl[0]  = '{1'b1, 12'h323, 32'h0000_FFFF, 1'b0, 32'h0, 1'b0};
      tbl[1]  = '{1'b0, 12'h323, 32'h0,         1'b1, 32'hF, 1'b0};
      tbl[2]  = '{1'b1, 12'h324, 32'h9,         1'b0, 32'h0, 1'b0};
      tbl[3]  = '{1'b0, 12'h324, 32'h0,         1'b1, 32'h9, 1'b0};
      tbl[4]  = '{1'b1, 12'h33F, 32'h5,         1'b0, 32'h0, 1'b0};
      tbl[5]  = '{1'b0, 12'h33F, 32'h0,         1'b1, 32'h0, 1'b0};
      tbl[6]  = '{1'b0, 12'hB1F, 32'h0,         1'b1, 32'h0, 1'b0};
      tbl[7]  = '{1'b0, 12'hB9F, 32'h0,         1'b1, 32'h0, 1'b0};
      tbl[8]  = '{1'b0, 12'h321, 32'h0,         1'b0, 32'h0, 1'b1};
      tbl[9]  = '{1'b0, 12'hB01, 32'h0,         1'b0, 32'h0, 1'b1};
      tbl[10] = '{1'b1, 12'hB81, 32'h1,         1'b0, 32'h0, 1'b1};
      tbl[11] = '{1'b0, 12'h000, 32'h0,         1'b0, 32'h0, 1'b1};
      tbl[12] = '{1'b1, 12'h320, 32'h2,         1'b0, 32'h0, 1'b0};
      tbl[13] = '{1'b0, 12'h320, 32'h0,         1'b1, 32'h0, 1'b0};
      tbl[14] = '{1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0};
      tbl[15] = '{1'b0, 12'h320, 32'h0,         1'b1, 32'h7D, 1'b0};
      tbl[16] = '{1'b1, 12'h320, 32'h0,         1'b0, 32'h0, 1'b0};
      tbl[17] = '{1'b0, 12'hC1F, 32'h0,         1'b1, 32'h0, 1'b0};
      tbl[18] = '{1'b1, 12'hC83, 32'h0,         1'b0, 32'h0, 1'b1};
      tbl[19] = '{1'b0, 12'hC83, 32'h0,         1'b1, 32'h0, 1'b0};

      rst_n   = 1'b0;
      retire  = 1'b0;
      events  = '0;
      addr    = '0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      wr_en40 = 1'b0;
      wr_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset rd_data", rd_data, 32'h0);
      chk("reset rd_valid", 32'(rd_valid), 32'h0);
      chk("reset illegal", 32'(illegal), 32'h0);
      chk("reset rd_data40", rd_data40, 32'h0);

      #2 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      do_rd(12'hC00);
      chk("cycle after 10 idle", rd_data, 32'd10);
      chk("cycle rd_valid", 32'(rd_valid), 32'h1);
      do_rd(12'hC02);
      chk("instret no retire", rd_data, 32'd0);

      do_wr(12'hC00, 32'h0, 1'b1, 1'b0);
      chk("write shadow illegal", 32'(illegal), 32'h1);
      exp_c = edge_cnt;
      do_rd(12'hB00);
      chk("mcycle after shadow write", rd_data, 32'(exp_c));
      chk("mcycle read legal", 32'(illegal), 32'h0);

      retire = 1'b1;
      idle(5);
      c_w = edge_cnt;
      do_wr(12'h320, 32'h5, 1'b1, 1'b0);
      idle(3);
      retire = 1'b0;
      do_rd(12'hB02);
      chk("minstret frozen", rd_data, 32'd6);
      do_rd(12'hB00);
      chk("mcycle frozen", rd_data, 32'(c_w + 1));
      idle(2);
      do_rd(12'hC00);
      chk("cycle shadow still frozen", rd_data, 32'(c_w + 1));

      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            do_wr(tbl[i].addr, tbl[i].data, 1'b1, 1'b0);
            chk($sformatf("vec%0d wr illegal", i), 32'(illegal), 32'(tbl[i].exp_ill));
            chk($sformatf("vec%0d wr rd_valid", i), 32'(rd_valid), 32'h0);
         end else begin
            do_rd(tbl[i].addr);
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'h1);
            chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(tbl[i].exp_ill));
            if (tbl[i].chk_data) begin
               chk($sformatf("vec%0d data", i), rd_data, tbl[i].exp_data);
            end
         end
      end

      do_wr(12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_wr(12'hB80, 32'h1, 1'b1, 1'b0);
      idle(3);
      do_rd(12'hB00);
      chk("wrap low", rd_data, 32'h2);
      do_rd(12'hB80);
      chk("wrap high", rd_data, 32'h2);

      do_wr(12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b1);
      do_rd(12'hB80);
      chk("w40 high truncated", rd_data40, 32'h0000_00FF);
      chk("main high untouched", rd_data, 32'h2);
      do_wr(12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b1);
      do_rd(12'hB80);
      chk("w40 full before wrap", rd_data40, 32'h0000_00FF);
      do_rd(12'hB80);
      chk("w40 high after wrap", rd_data40, 32'h0);
      do_rd(12'hB00);
      chk("w40 low after wrap", rd_data40, 32'h1);

      do_wr(12'h323, 32'h2, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         events = 8'h02;
         @(posedge clk);
         @(negedge clk);
         events = 8'h00;
      end
      for (int k = 0; k < 7; k++) begin
         events = 8'h01;
         @(posedge clk);
         @(negedge clk);
         events = 8'h00;
      end
      do_rd(12'hB03);
      chk("hpm3 event 2 count", rd_data, 32'd5);
      for (int k = 0; k < 3; k++) begin
         events = 8'hFF;
         @(posedge clk);
         @(negedge clk);
         events = 8'h00;
      end
      do_rd(12'hB04);
      chk("hpm4 selector 9", rd_data, 32'd0);
      do_rd(12'hB03);
      chk("hpm3 after all events", rd_data, 32'd8);

      events = 8'h02;
      do_wr(12'hB03, 32'd100, 1'b1, 1'b0);
      events = 8'h00;
      do_rd(12'hB03);
      chk("hpm3 write beats event", rd_data, 32'd100);
      events = 8'h02;
      @(posedge clk);
      @(negedge clk);
      events = 8'h00;
      do_rd(12'hC03);
      chk("hpm3 resumes", rd_data, 32'd101);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset rd_data", rd_data, 32'h0);
      chk("async reset illegal", 32'(illegal), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_rd(12'hB00);
      chk("post reset mcycle", rd_data, 32'h0);
      do_rd(12'hB02);
      chk("post reset minstret", rd_data, 32'h0);
      do_rd(12'hB03);
      chk("post reset hpm3", rd_data, 32'h0);
      do_rd(12'h323);
      chk("post reset mhpmevent3", rd_data, 32'h0);
      do_rd(12'h320);
      chk("post reset mcountinhibit", rd_data, 32'h0);
      do_rd(12'hB80);
      chk("post reset w40 high", rd_data40, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
